alu_src_stage: RTL
==================

Name: alu_src_stage

Overview:
- Registered operand-select stage between the register file / negation unit and the ALU.
- Picks OPERAND2 from three sources: the raw register value, its two's-complement negation, or the immediate. Latches both operands with the control fields.
- Presents the result to the ALU through a valid/ready handshake.
- A 2-entry skid buffer gives full throughput under backpressure.

Parameters:
- WIDTH, 8, data width of operands and immediate.
- OPW, 3, width of ALUOP.
- DSTW, 3, width of destination register index.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  synchronous reset, active-low.
- IN_VALID  input  1  upstream has a decoded instruction's operands.
- IN_READY  output  1  stage can accept a transfer this cycle.
- REGOUT1  input  WIDTH  first register operand.
- REGOUT2  input  WIDTH  second register operand, raw.
- NEG_REGOUT2  input  WIDTH  two's complement of REGOUT2 from the negation unit.
- IMMEDIATE  input  WIDTH  immediate field.
- IMM_SEL  input  1  select immediate for operand 2.
- SUB_SEL  input  1  select negated REGOUT2 for operand 2.
- ALUOP  input  OPW  ALU function code, passed through.
- DEST  input  DSTW  destination index, passed through.
- OUT_VALID  output  1  OPERAND1/OPERAND2/fields hold a valid entry.
- OUT_READY  input  1  ALU consumes the entry this cycle.
- OPERAND1  output  WIDTH  registered REGOUT1.
- OPERAND2  output  WIDTH  registered selected operand 2.
- OUT_ALUOP  output  OPW  registered ALUOP.
- OUT_DEST  output  DSTW  registered DEST.
- NEG_OVF  output  1  registered flag: the negated operand was the most-negative value.

Behaviour:
- Transfers:
  - Input transfer = IN_VALID & IN_READY at a rising edge.
  - Output transfer = OUT_VALID & OUT_READY at a rising edge.
- Operand 2 select:
  - IMM_SEL=1 -> IMMEDIATE, SUB_SEL ignored.
  - Else SUB_SEL=1 -> NEG_REGOUT2.
  - Else -> REGOUT2.
  - NEG_REGOUT2 is used as supplied; no recomputation and no width extension.
- NEG_OVF = !IMM_SEL & SUB_SEL & (REGOUT2 == 1 followed by WIDTH-1 zeros). It is captured with its entry; the negation of 8'h80 is 8'h80.
- Storage:
  - Main register drives the outputs.
  - One skid register holds the same fields.
- State machine, registered:
  - EMPTY:
    - Input transfer -> load main; go to ONE.
  - ONE:
    - Input and output transfer -> load main with new entry; stay ONE.
    - Input transfer only -> load skid; go to FULL.
    - Output transfer only -> go to EMPTY.
    - Neither -> hold.
  - FULL:
    - Output transfer -> main <= skid; go to ONE.
    - Otherwise hold.
    - IN_READY=0, so no input transfer is possible.
- Outputs:
  - OUT_VALID = (state != EMPTY).
  - IN_READY = RESET & (state != FULL). It depends only on state and reset, never combinationally on OUT_READY.
- Latency and throughput:
  - Latency is 1 cycle: an input transfer into EMPTY gives OUT_VALID=1 on the next cycle.
  - Sustained throughput is 1 entry/cycle while OUT_READY=1.
- Ordering is strict FIFO; no entry is dropped or duplicated.
- Stability: while OUT_VALID=1 and OUT_READY=0, all outputs hold bit-stable.
- Inputs are sampled only on an input transfer; IN_VALID=0 contents are don't-care.
- Reset (RESET=0 at a rising edge), regardless of state, including mid-backpressure:
  - State -> EMPTY.
  - OUT_VALID=0; OPERAND1, OPERAND2, OUT_ALUOP, OUT_DEST, NEG_OVF all 0.
  - Skid contents cleared.
  - While RESET=0, IN_READY=0 and inputs are ignored.
  - First input transfer is possible on the first edge with RESET=1.
- OUT_READY with OUT_VALID=0 has no effect.

Test Plan:
- Add path: REGOUT1=8'h05, REGOUT2=8'h03, IMM_SEL=0, SUB_SEL=0, ALUOP=3'b001, DEST=2, OUT_READY=1 -> next cycle OUT_VALID=1, OPERAND1=05, OPERAND2=03, OUT_ALUOP=001, OUT_DEST=2, NEG_OVF=0.
- Sub / immediate select:
  - REGOUT2=03, NEG_REGOUT2=FD, SUB_SEL=1 -> OPERAND2=FD.
  - Next cycle IMM_SEL=1, SUB_SEL=1, IMMEDIATE=7A -> OPERAND2=7A, NEG_OVF=0.
  - Both entries arrive in order, one per cycle.
- Most-negative: SUB_SEL=1, REGOUT2=80, NEG_REGOUT2=80 -> OPERAND2=80, NEG_OVF=1. The same with IMM_SEL=1 -> NEG_OVF=0.
- Backpressure:
  - Hold OUT_READY=0 and push entries A, B, C with IN_VALID=1 -> A accepted, B accepted, IN_READY=0; C held upstream; outputs show A stable.
  - Release OUT_READY=1 -> A, B, C emerge on consecutive cycles, no loss or duplication.
- Reset mid-operation:
  - In FULL state, drive RESET=0 for one edge -> OUT_VALID=0, all outputs 0, IN_READY=0 during reset.
  - After RESET=1, a single new entry emerges with 1-cycle latency; old entries never appear.
- Simultaneous transfer in ONE: with OUT_READY=1 and IN_VALID=1 each cycle over 8 entries -> state stays ONE, IN_READY stays 1, output sequence matches input sequence exactly.

Source files
------------

// File: rtl/alu_src_stage_if.sv
// Handshake and operand bus between the decode side, the operand-select stage and the ALU.
interface alu_src_stage_if #(
  parameter int WIDTH = 8,
  parameter int OPW   = 3,
  parameter int DSTW  = 3
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] REGOUT1;
  logic [WIDTH-1:0] REGOUT2;
  logic [WIDTH-1:0] NEG_REGOUT2;
  logic [WIDTH-1:0] IMMEDIATE;
  logic             IMM_SEL;
  logic             SUB_SEL;
  logic [OPW-1:0]   ALUOP;
  logic [DSTW-1:0]  DEST;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] OPERAND1;
  logic [WIDTH-1:0] OPERAND2;
  logic [OPW-1:0]   OUT_ALUOP;
  logic [DSTW-1:0]  OUT_DEST;
  logic             NEG_OVF;

  // Stage side: consumes operands, produces the latched ALU entry.
  modport slave (
    input  IN_VALID, REGOUT1, REGOUT2, NEG_REGOUT2, IMMEDIATE, IMM_SEL, SUB_SEL,
           ALUOP, DEST, OUT_READY,
    output IN_READY, OUT_VALID, OPERAND1, OPERAND2, OUT_ALUOP, OUT_DEST, NEG_OVF
  );

  // Environment side: drives operands upstream and ready downstream.
  modport master (
    output IN_VALID, REGOUT1, REGOUT2, NEG_REGOUT2, IMMEDIATE, IMM_SEL, SUB_SEL,
           ALUOP, DEST, OUT_READY,
    input  IN_READY, OUT_VALID, OPERAND1, OPERAND2, OUT_ALUOP, OUT_DEST, NEG_OVF
  );
endinterface

// File: rtl/alu_src_stage.sv
// Registered operand-2 select stage with a 2-entry skid buffer feeding the ALU.
module alu_src_stage #(
  parameter int WIDTH = 8,
  parameter int OPW   = 3,
  parameter int DSTW  = 3
) (
  input  logic            CLK,
  input  logic            RESET,
  alu_src_stage_if.slave  bus
);

  typedef struct packed {
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [OPW-1:0]   aluop;
    logic [DSTW-1:0]  dest;
    logic             neg_ovf;
  } entry_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t new_entry;
  logic   in_ready, in_xfer, out_xfer;

  // Build the incoming entry: immediate wins over negation, negation over raw.
  always_comb begin
    new_entry       = '0;
    new_entry.op1   = bus.REGOUT1;
    new_entry.aluop = bus.ALUOP;
    new_entry.dest  = bus.DEST;
    if (bus.IMM_SEL)      new_entry.op2 = bus.IMMEDIATE;
    else if (bus.SUB_SEL) new_entry.op2 = bus.NEG_REGOUT2;
    else                  new_entry.op2 = bus.REGOUT2;
    // Negating the most-negative value wraps back onto itself.
    new_entry.neg_ovf = !bus.IMM_SEL && bus.SUB_SEL &&
                        (bus.REGOUT2 == {1'b1, {(WIDTH-1){1'b0}}});
  end

  // Next-state and storage updates for the EMPTY/ONE/FULL occupancy machine.
  always_comb begin
    in_ready = RESET && (state_q != FULL);
    in_xfer  = bus.IN_VALID && in_ready;
    out_xfer = (state_q != EMPTY) && bus.OUT_READY;
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_d  = new_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = new_entry;
        end else if (in_xfer) begin
          skid_d  = new_entry;
          state_d = FULL;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State and entry registers; reset clears everything including the skid.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign bus.IN_READY  = in_ready;
  assign bus.OUT_VALID = (state_q != EMPTY);
  assign bus.OPERAND1  = main_q.op1;
  assign bus.OPERAND2  = main_q.op2;
  assign bus.OUT_ALUOP = main_q.aluop;
  assign bus.OUT_DEST  = main_q.dest;
  assign bus.NEG_OVF   = main_q.neg_ovf;

endmodule
